// File: rtl/cache_ctrl.sv
// Direct-mapped cache set sequencer: compare, dirty write-back, line fill and retry.
// Optional feature macro CACHE_STATS_EN adds saturating hit/miss counters.
module cache_ctrl #(
  parameter int TAG_W  = 5,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  localparam int ADDR_W = TAG_W + IDX_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              busy,
  output logic              set_enable,
  output logic              set_cmp,
  output logic              set_write,
  output logic [1:0]        set_word,
  output logic [IDX_W-1:0]  set_index,
  output logic [TAG_W-1:0]  set_tag,
  output logic [DATA_W-1:0] set_data_in,
  output logic              set_valid_in,
  input  logic              set_hit,
  input  logic              set_dirty,
  input  logic              set_valid,
  input  logic [TAG_W-1:0]  set_tag_out,
  input  logic [DATA_W-1:0] set_data_out,
  input  logic              set_ack,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
`endif
  input  logic              mem_ack
);

  // state    | meaning
  // IDLE     | waiting for cpu_req
  // CMP      | compare access (first try or retry after fill)
  // WB_RD    | direct read of victim word k
  // WB_MEM   | memory write of victim word k
  // FILL_MEM | memory read of requested line word k
  // FILL_WR  | direct write of word k into the set
  // DONE     | cpu_ack pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_WB_RD, S_WB_MEM, S_FILL_MEM, S_FILL_WR, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic               req_wr;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic [1:0]         k;
  logic [DATA_W-1:0]  line_buf;
  logic [TAG_W-1:0]   victim_tag;
  logic [DATA_W-1:0]  rdata_q;
  logic               gap;
  logic               retry;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [1:0]         req_word;

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[2 +: IDX_W];
  assign req_word = req_addr[1:0];

  // gap holds every strobe low for one cycle after any acknowledged operation
  always_comb begin
    state_nx     = state;
    busy         = (state != S_IDLE);
    cpu_ack      = 1'b0;
    cpu_rdata    = '0;
    set_enable   = 1'b0;
    set_cmp      = 1'b0;
    set_write    = 1'b0;
    set_word     = '0;
    set_index    = '0;
    set_tag      = '0;
    set_data_in  = '0;
    set_valid_in = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state)
      S_IDLE: if (cpu_req) state_nx = S_CMP;
      S_CMP: begin
        set_enable  = !gap;
        set_cmp     = 1'b1;
        set_write   = req_wr;
        set_word    = req_word;
        set_index   = req_idx;
        set_tag     = req_tag;
        set_data_in = req_wdata;
        if (set_enable && set_ack) begin
          if (set_hit)                      state_nx = S_DONE;
          else if (set_valid && set_dirty)  state_nx = S_WB_RD;
          else                              state_nx = S_FILL_MEM;
        end
      end
      S_WB_RD: begin
        set_enable = !gap;
        set_word   = k;
        set_index  = req_idx;
        set_tag    = req_tag;
        if (set_enable && set_ack) state_nx = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_req   = !gap;
        mem_wr    = 1'b1;
        mem_addr  = {victim_tag, req_idx, k};
        mem_wdata = line_buf;
        if (mem_req && mem_ack) state_nx = (k == 2'd3) ? S_FILL_MEM : S_WB_RD;
      end
      S_FILL_MEM: begin
        mem_req  = !gap;
        mem_addr = {req_tag, req_idx, k};
        if (mem_req && mem_ack) state_nx = S_FILL_WR;
      end
      S_FILL_WR: begin
        set_enable   = !gap;
        set_write    = 1'b1;
        set_word     = k;
        set_index    = req_idx;
        set_tag      = req_tag;
        set_data_in  = line_buf;
        set_valid_in = 1'b1;
        if (set_enable && set_ack) state_nx = (k == 2'd3) ? S_CMP : S_FILL_MEM;
      end
      S_DONE: begin
        cpu_ack   = 1'b1;
        cpu_rdata = rdata_q;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_wr     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      k          <= '0;
      line_buf   <= '0;
      victim_tag <= '0;
      rdata_q    <= '0;
      gap        <= 1'b0;
      retry      <= 1'b0;
    end else begin
      state <= state_nx;
      gap   <= (set_enable && set_ack) || (mem_req && mem_ack);
      case (state)
        S_IDLE: if (cpu_req) begin
          req_wr    <= cpu_wr;
          req_addr  <= cpu_addr;
          req_wdata <= cpu_wdata;
          retry     <= 1'b0;
        end
        S_CMP: if (set_enable && set_ack) begin
          rdata_q <= req_wr ? '0 : set_data_out;
          k       <= '0;
        end
        S_WB_RD: if (set_enable && set_ack) begin
          victim_tag <= set_tag_out;
          line_buf   <= set_data_out;
        end
        S_WB_MEM:   if (mem_req && mem_ack) k <= k + 2'd1;
        S_FILL_MEM: if (mem_req && mem_ack) line_buf <= mem_rdata;
        S_FILL_WR: if (set_enable && set_ack) begin
          k <= k + 2'd1;
          if (k == 2'd3) retry <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // only the first compare of a request counts; the post-fill retry is excluded
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_CMP && set_enable && set_ack && !retry) begin
      if (set_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural set and memory models plus a flat-memory cache reference.
module tb_cache_ctrl;
  localparam int CNT_W_TB = 4;
  localparam int CNT_MAX  = (1 << CNT_W_TB) - 1;

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] data;
  } mem_op_t;

  logic clk, rst;
  logic cpu_req, cpu_wr;
  logic [9:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic cpu_ack, busy;
  logic set_enable, set_cmp, set_write, set_valid_in;
  logic [1:0] set_word;
  logic [2:0] set_index;
  logic [4:0] set_tag, set_tag_out;
  logic [15:0] set_data_in, set_data_out;
  logic set_hit, set_dirty, set_valid, set_ack;
  logic mem_req, mem_wr, mem_ack;
  logic [9:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [CNT_W_TB-1:0] hit_cnt, miss_cnt;
`endif

  cache_ctrl #(.TAG_W(5), .IDX_W(3), .DATA_W(16), .CNT_W(CNT_W_TB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy(busy),
    .set_enable(set_enable), .set_cmp(set_cmp), .set_write(set_write), .set_word(set_word),
    .set_index(set_index), .set_tag(set_tag), .set_data_in(set_data_in), .set_valid_in(set_valid_in),
    .set_hit(set_hit), .set_dirty(set_dirty), .set_valid(set_valid), .set_tag_out(set_tag_out),
    .set_data_out(set_data_out), .set_ack(set_ack),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef CACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_ack(mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // set bank model
  logic        s_val   [8];
  logic        s_dirty [8];
  logic [4:0]  s_tag   [8];
  logic [15:0] s_data  [8][4];
  int set_max = 3, set_fixed = -1, s_wait = 0;
  logic s_pend = 1'b0;

  // backing memory model
  logic [15:0] mem [1024];
  int mem_max = 3, mem_fixed = -1, m_wait = 0;
  logic m_pend = 1'b0;
  mem_op_t obs_q[$];

  // reference: flat coherent memory image plus per-index line state
  logic [15:0] image [1024];
  logic        r_val   [8];
  logic        r_dirty [8];
  logic [4:0]  r_tag   [8];
  int exp_hits = 0, exp_misses = 0;

  logic mon_skip = 1'b1;

  always @(negedge clk) begin
    if (set_ack) begin
      set_ack      = 1'b0;
      set_hit      = 1'($urandom);
      set_dirty    = 1'($urandom);
      set_valid    = 1'($urandom);
      set_tag_out  = 5'($urandom);
      set_data_out = 16'($urandom);
    end else if (set_enable) begin
      if (!s_pend) begin
        s_pend = 1'b1;
        s_wait = (set_fixed >= 0) ? set_fixed : int'($urandom_range(set_max, 0));
      end
      if (s_wait == 0) begin
        set_valid   = s_val[set_index];
        set_dirty   = s_dirty[set_index];
        set_tag_out = s_tag[set_index];
        set_hit     = 1'b0;
        if (set_cmp) begin
          set_hit = s_val[set_index] && (s_tag[set_index] == set_tag);
          if (set_hit && set_write) begin
            s_data[set_index][set_word] = set_data_in;
            s_dirty[set_index] = 1'b1;
          end
        end else if (set_write) begin
          s_data[set_index][set_word] = set_data_in;
          s_tag[set_index]   = set_tag;
          s_val[set_index]   = set_valid_in;
          s_dirty[set_index] = 1'b0;
        end
        set_data_out = s_data[set_index][set_word];
        set_ack = 1'b1;
        s_pend  = 1'b0;
      end else s_wait--;
    end else s_pend = 1'b0;
  end

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
    end else if (mem_req) begin
      if (!m_pend) begin
        m_pend = 1'b1;
        m_wait = (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(mem_max, 0));
      end
      if (m_wait == 0) begin
        if (mem_wr) begin
          mem[mem_addr] = mem_wdata;
          obs_q.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr];
          obs_q.push_back({1'b0, mem_addr, mem[mem_addr]});
        end
        mem_ack = 1'b1;
        m_pend  = 1'b0;
      end else m_wait--;
    end else m_pend = 1'b0;
  end

  // protocol monitor: operand hold, one-cycle drop after ack, hit latency
  logic        p_set_en = 1'b0, p_mem_en = 1'b0;
  logic [27:0] p_set_ops;
  logic [26:0] p_mem_ops;
  always @(posedge clk) begin
    #1;
    if (!mon_skip) begin
      if (p_set_en) begin
        vectors++;
        if (set_ack) begin
          if (set_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL set_gap: set_enable=%b after set_ack, required 0", set_enable);
          end
        end else if (set_enable !== 1'b1 ||
                     {set_cmp, set_write, set_word, set_index, set_tag, set_data_in} !== p_set_ops) begin
          miscompares++;
          $display("FAIL set_hold: en=%b ops=%h, required en=1 ops=%h", set_enable,
                   {set_cmp, set_write, set_word, set_index, set_tag, set_data_in}, p_set_ops);
        end
      end
      if (p_mem_en) begin
        vectors++;
        if (mem_ack) begin
          if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_gap: mem_req=%b after mem_ack, required 0", mem_req);
          end
        end else if (mem_req !== 1'b1 || {mem_wr, mem_addr, mem_wdata} !== p_mem_ops) begin
          miscompares++;
          $display("FAIL mem_hold: req=%b ops=%h, required req=1 ops=%h", mem_req,
                   {mem_wr, mem_addr, mem_wdata}, p_mem_ops);
        end
      end
      if (cpu_ack === 1'b1) begin
        vectors++;
        if (!(set_ack && p_set_en)) begin
          miscompares++;
          $display("FAIL ack_latency: cpu_ack not 1 cycle after compare set_ack (set_ack=%b prev_en=%b)",
                   set_ack, p_set_en);
        end
      end
    end
    p_set_en  = set_enable;
    p_set_ops = {set_cmp, set_write, set_word, set_index, set_tag, set_data_in};
    p_mem_en  = mem_req;
    p_mem_ops = {mem_wr, mem_addr, mem_wdata};
  end

  function automatic logic [9:0] mk_addr(input logic [4:0] t, input logic [2:0] i, input logic [1:0] w);
    return {t, i, w};
  endfunction

  task automatic check_stats(input string name);
`ifdef CACHE_STATS_EN
    vectors++;
    if (hit_cnt !== CNT_W_TB'(exp_hits) || miss_cnt !== CNT_W_TB'(exp_misses)) begin
      miscompares++;
      $display("FAIL %s stats: hit=%0d miss=%0d, required hit=%0d miss=%0d", name, hit_cnt, miss_cnt,
               exp_hits, exp_misses);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic do_req(input logic wr, input logic [9:0] addr, input logic [15:0] wdata, input string name);
    mem_op_t exp_q[$];
    logic [2:0] idx;
    logic [4:0] tg;
    logic [1:0] w;
    logic hit, got;
    logic [15:0] exp_rd, rd;
    idx = addr[4:2];
    tg  = addr[9:5];
    hit = r_val[idx] && (r_tag[idx] == tg);
    if (!hit) begin
      if (r_val[idx] && r_dirty[idx])
        for (int k = 0; k < 4; k++) begin
          w = k[1:0];
          exp_q.push_back({1'b1, mk_addr(r_tag[idx], idx, w), image[mk_addr(r_tag[idx], idx, w)]});
        end
      for (int k = 0; k < 4; k++) begin
        w = k[1:0];
        exp_q.push_back({1'b0, mk_addr(tg, idx, w), image[mk_addr(tg, idx, w)]});
      end
    end
    exp_rd = wr ? 16'h0 : image[addr];
    obs_q.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    got = 1'b0;
    rd  = '0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); #1;
      if (cpu_ack === 1'b1) begin
        got = 1'b1;
        rd  = cpu_rdata;
      end
    end
    cpu_req = 1'b0; cpu_wr = 1'($urandom); cpu_addr = 10'($urandom); cpu_wdata = 16'($urandom);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s timeout: no cpu_ack, required one within 3000 cycles", name);
    end else begin
      vectors++;
      if (rd !== exp_rd) begin
        miscompares++;
        $display("FAIL %s rdata: got %h, required %h", name, rd, exp_rd);
      end
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL %s mem_ops: got %0d ops, required %0d", name, obs_q.size(), exp_q.size());
      end else
        for (int i = 0; i < exp_q.size(); i++) begin
          vectors++;
          if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s mem_op[%0d]: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                     name, i, obs_q[i].wr, obs_q[i].addr, obs_q[i].data,
                     exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
          end
        end
      @(posedge clk); #1;
      vectors++;
      if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ack_pulse: cpu_ack=%b busy=%b a cycle later, required 0 0", name, cpu_ack, busy);
      end
    end
    if (hit) exp_hits = (exp_hits == CNT_MAX) ? CNT_MAX : exp_hits + 1;
    else begin
      exp_misses = (exp_misses == CNT_MAX) ? CNT_MAX : exp_misses + 1;
      r_val[idx] = 1'b1; r_tag[idx] = tg; r_dirty[idx] = 1'b0;
    end
    if (wr) begin
      image[addr] = wdata;
      r_dirty[idx] = 1'b1;
    end
    check_stats(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cpu_ack, cpu_rdata, busy, set_enable, set_cmp, set_write, set_word, set_index, set_tag,
         set_data_in, set_valid_in, mem_req, mem_wr, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b set_en=%b mem_req=%b mem_addr=%h, required all 0",
               busy, set_enable, mem_req, mem_addr);
    end
    exp_hits = 0; exp_misses = 0;
    check_stats("reset");
    @(negedge clk);
    rst = 1'b0;
    mon_skip = 1'b0;
  endtask

  task automatic test_cold_load();
    do_req(1'b0, mk_addr(5'b11101, 3'd2, 2'd3), 16'h0, "cold_load");
  endtask

  task automatic test_store_hit();
    do_req(1'b1, mk_addr(5'b11101, 3'd2, 2'd3), 16'h0F0F, "store_hit");
    do_req(1'b0, mk_addr(5'b11101, 3'd2, 2'd3), 16'h0, "load_after_store");
    vectors++;
    if (s_dirty[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL store_dirty: set dirty=%b, required 1", s_dirty[2]);
    end
  endtask

  task automatic test_dirty_evict();
    do_req(1'b0, mk_addr(5'b00001, 3'd2, 2'd0), 16'h0, "dirty_evict");
    vectors++;
    if (mem[mk_addr(5'b11101, 3'd2, 2'd3)] !== 16'h0F0F) begin
      miscompares++;
      $display("FAIL evict_word3: mem=%h, required 0f0f", mem[mk_addr(5'b11101, 3'd2, 2'd3)]);
    end
`ifdef CACHE_STATS_EN
    vectors++;
    if (hit_cnt !== 2 || miss_cnt !== 2) begin
      miscompares++;
      $display("FAIL stats_after_3: hit=%0d miss=%0d, required 2 2", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_req(1'b1, mk_addr(5'b00001, 3'd2, 2'd0), 16'hBEEF, "mid_store");
    mem_fixed = 6;
    obs_q.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = mk_addr(5'b00111, 3'd2, 2'd1); cpu_wdata = 16'h0;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(posedge clk); #1;
      if (obs_q.size() == 1 && mem_req === 1'b1 && mem_wr === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_reach: second write-back write not seen, required within 500 cycles");
    end
    mon_skip = 1'b1;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({cpu_ack, busy, set_enable, mem_req, mem_wr, mem_addr, mem_wdata, set_index, set_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: busy=%b set_en=%b mem_req=%b mem_addr=%h, required all 0",
               busy, set_enable, mem_req, mem_addr);
    end
    rst = 1'b0;
    exp_hits = 0; exp_misses = 0;
    repeat (2) @(posedge clk);
    #1;
    mon_skip = 1'b0;
    mem_fixed = -1;
    do_req(1'b0, mk_addr(5'b00111, 3'd2, 2'd1), 16'h0, "restart_after_reset");
  endtask

  task automatic test_stall();
    set_fixed = 10; mem_fixed = 10;
    do_req(1'b1, mk_addr(5'b00111, 3'd2, 2'd2), 16'h1234, "stall_store");
    do_req(1'b0, mk_addr(5'b01010, 3'd2, 2'd0), 16'h0, "stall_evict");
    set_fixed = -1; mem_fixed = -1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++)
      do_req(1'($urandom), mk_addr(5'($urandom_range(3, 0)), 3'($urandom), 2'($urandom)),
             16'($urandom), "random");
  endtask

  task automatic test_saturate();
    for (int n = 0; n < CNT_MAX + 3; n++)
      do_req(1'b0, mk_addr(5'd0, 3'd5, 2'(n)), 16'h0, "saturate");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      image[i] = 16'($urandom);
      mem[i]   = image[i];
    end
    for (int i = 0; i < 8; i++) begin
      s_val[i] = 1'b0; s_dirty[i] = 1'b0; s_tag[i] = 5'($urandom);
      r_val[i] = 1'b0; r_dirty[i] = 1'b0; r_tag[i] = 5'd0;
      for (int j = 0; j < 4; j++) s_data[i][j] = 16'($urandom);
    end
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    set_ack = 1'b0; set_hit = 1'b0; set_dirty = 1'b0; set_valid = 1'b0;
    set_tag_out = '0; set_data_out = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_reset_mid();
    test_stall();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
